// File: rtl/and_result_monitor.sv
// and_result_monitor: checks an AND gate's output against a & b on every
// valid sample. It counts samples and mismatches, logs mismatching {a,b,y}
// vectors in a small first-word-fall-through FIFO, and reports pass/fail
// once the captured sample target has been reached.
//
// Optional feature (macro AND_MON_STOP_ON_ERR_EN): the first mismatch seen
// in RUN ends the run on the next edge, with pass=0.
//
// state  | meaning
// IDLE   | no run started since reset
// RUN    | checking in_valid samples toward the captured target
// DONE   | run finished; pass is valid, log remains readable
module and_result_monitor #(
  parameter int WIDTH     = 1,
  parameter int CNT_W     = 16,
  parameter int LOG_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_samples,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   y,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [CNT_W-1:0]   sample_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  input  logic               log_rd_en,
  output logic [3*WIDTH-1:0] log_rd_data,
  output logic               log_empty,
  output logic               log_overflow
);

  localparam int AW = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;
  localparam int PW = AW + 1;
  localparam int DW = 3 * WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]    PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] sample_q;
  logic [CNT_W-1:0] err_q;
  logic             pass_q;
  logic             ovf_q;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [DW-1:0]    mem [LOG_DEPTH];

  logic             accept;
  logic             mismatch;
  logic             finish;
  logic [CNT_W-1:0] sample_inc;
  logic [CNT_W-1:0] err_inc;
  logic [CNT_W-1:0] err_next;
  logic             log_full;
  logic             push;
  logic             push_ok;
  logic             pop;

  // Sample acceptance, mismatch detection, saturating increments, run end
  always_comb begin
    accept     = (state == S_RUN) && in_valid && !start;
    // Case-inequality so an X/Z on y is reported as a mismatch in simulation
    mismatch   = (y !== (a & b));
    sample_inc = (&sample_q) ? sample_q : sample_q + CNT_ONE;
    err_inc    = (&err_q) ? err_q : err_q + CNT_ONE;
    err_next   = (accept && mismatch) ? err_inc : err_q;
`ifdef AND_MON_STOP_ON_ERR_EN
    finish     = accept && ((sample_inc == target) || mismatch);
`else
    finish     = accept && (sample_inc == target);
`endif
  end

  // Log occupancy and push/pop qualification; start flushes the log instead
  always_comb begin
    log_empty = (wr_ptr == rd_ptr);
    log_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop       = log_rd_en && !log_empty && !start;
    push      = accept && mismatch;
    // A simultaneous pop frees the slot, so a push into a full log still lands
    push_ok   = push && (!log_full || pop);
  end

  // Run FSM, target capture, counters and pass flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      target   <= '0;
      sample_q <= '0;
      err_q    <= '0;
      pass_q   <= 1'b0;
    end else if (start) begin
      target   <= num_samples;
      sample_q <= '0;
      err_q    <= '0;
      if (num_samples == '0) begin
        state  <= S_DONE;
        pass_q <= 1'b1;
      end else begin
        state  <= S_RUN;
        pass_q <= 1'b0;
      end
    end else if (accept) begin
      sample_q <= sample_inc;
      err_q    <= err_next;
      if (finish) begin
        state  <= S_DONE;
        pass_q <= (err_next == '0);
      end
    end
  end

  // Log pointers and sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_q  <= 1'b0;
    end else if (start) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !push_ok) ovf_q <= 1'b1;
    end
  end

  // Log storage; contents need no reset because reads are gated by log_empty
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= {a, b, y};
  end

  // Status outputs
  always_comb begin
    busy         = (state == S_RUN);
    done         = (state == S_DONE);
    pass         = pass_q;
    sample_cnt   = sample_q;
    err_cnt      = err_q;
    log_overflow = ovf_q;
    log_rd_data  = log_empty ? '0 : mem[rd_ptr[AW-1:0]];
  end

endmodule

// File: tb/tb_and_result_monitor.sv
// Testbench for and_result_monitor (default parameters). Honors
// AND_MON_STOP_ON_ERR_EN when the design is built with it.
module tb_and_result_monitor;

  localparam int LOG_DEPTH = 4;
  localparam int CNT_MAX   = 65535;
`ifdef AND_MON_STOP_ON_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] num_samples;
  logic        in_valid;
  logic [0:0]  a, b, y;
  logic        busy, done, pass;
  logic [15:0] sample_cnt, err_cnt;
  logic        log_rd_en;
  logic [2:0]  log_rd_data;
  logic        log_empty, log_overflow;

  and_result_monitor #(.WIDTH(1), .CNT_W(16), .LOG_DEPTH(LOG_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .a(a), .b(b), .y(y),
    .busy(busy), .done(done), .pass(pass),
    .sample_cnt(sample_cnt), .err_cnt(err_cnt),
    .log_rd_en(log_rd_en), .log_rd_data(log_rd_data),
    .log_empty(log_empty), .log_overflow(log_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural reference: run/done flags, plain counts and a queue log
  bit         m_run, m_done, m_pass, m_ovf;
  int         m_target, m_samp, m_errs;
  logic [2:0] m_q[$];

  typedef struct {
    bit   st; int ns; bit iv; logic av, bv, yv;
    int   e_samp; int e_err; bit e_busy; bit e_done; bit e_pass; bit e_empty;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit st, int ns, bit iv, logic av, logic bv, logic yv,
                              int es, int ee, bit eb, bit ed, bit ep, bit em);
    vec_t v;
    v.st = st; v.ns = ns; v.iv = iv; v.av = av; v.bv = bv; v.yv = yv;
    v.e_samp = es; v.e_err = ee; v.e_busy = eb; v.e_done = ed; v.e_pass = ep; v.e_empty = em;
    return v;
  endfunction

  function automatic int sat(int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_done = 0; m_pass = 0; m_ovf = 0;
    m_target = 0; m_samp = 0; m_errs = 0;
    m_q.delete();
  endtask

  task automatic model_edge(input bit st, input int ns, input bit iv,
                            input logic av, input logic bv, input logic yv, input bit rd);
    bit mism;
    logic [2:0] tmp;
    if (st) begin
      m_q.delete(); m_ovf = 0; m_samp = 0; m_errs = 0; m_target = ns;
      if (ns == 0) begin m_run = 0; m_done = 1; m_pass = 1; end
      else begin m_run = 1; m_done = 0; m_pass = 0; end
    end else begin
      if (rd && m_q.size() > 0) tmp = m_q.pop_front();
      if (m_run && iv) begin
        mism = (yv !== (av & bv));
        m_samp = sat(m_samp + 1);
        if (mism) begin
          m_errs = sat(m_errs + 1);
          if (m_q.size() < LOG_DEPTH) m_q.push_back({av, bv, yv});
          else m_ovf = 1;
        end
        if (m_samp == m_target || (STOP && mism)) begin
          m_run = 0; m_done = 1; m_pass = (m_errs == 0);
        end
      end
    end
  endtask

  task automatic compare_model();
    logic [2:0] exp_rd;
    exp_rd = (m_q.size() > 0) ? m_q[0] : 3'b000;
    check("busy", 64'(busy), 64'(m_run));
    check("done", 64'(done), 64'(m_done));
    if (m_done) check("pass", 64'(pass), 64'(m_pass));
    check("sample_cnt", 64'(sample_cnt), 64'(m_samp));
    check("err_cnt", 64'(err_cnt), 64'(m_errs));
    check("log_empty", 64'(log_empty), 64'(m_q.size() == 0));
    check("log_overflow", 64'(log_overflow), 64'(m_ovf));
    check("log_rd_data", 64'(log_rd_data), 64'(exp_rd));
  endtask

  // One clock: drive inputs, advance the model, compare after the edge
  task automatic cyc(input bit st, input int ns, input bit iv,
                     input logic av, input logic bv, input logic yv, input bit rd);
    start = st; num_samples = 16'(ns); in_valid = iv;
    a = av; b = bv; y = yv; log_rd_en = rd;
    model_edge(st, ns, iv, av, bv, yv, rd);
    @(posedge clk); #1;
    compare_model();
  endtask

  initial begin
    logic [2:0] ov_list[6];
    bit ra, rb;

    rst_n = 1'b0; start = 0; num_samples = '0; in_valid = 0;
    a = '0; b = '0; y = '0; log_rd_en = 0;
    model_reset();
    #12;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_pass", 64'(pass), 64'd0);
    check("reset_sample_cnt", 64'(sample_cnt), 64'd0);
    check("reset_err_cnt", 64'(err_cnt), 64'd0);
    check("reset_log_empty", 64'(log_empty), 64'd1);
    check("reset_log_overflow", 64'(log_overflow), 64'd0);
    check("reset_log_rd_data", 64'(log_rd_data), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Exhaustive pass run, then a run with one mismatch on the third sample
    tbl.push_back(mk(1, 4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 2, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 3, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 1, 1, 1, 4, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 4, 0, 0, 1, 1, 1));
    tbl.push_back(mk(1, 4, 1, 1, 1, 0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 2, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 1, 0, 1, 3, 1, !STOP, STOP, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 1, 1, STOP ? 3 : 4, 1, 0, 1, 0, 0));
    foreach (tbl[i]) begin
      cyc(tbl[i].st, tbl[i].ns, tbl[i].iv, tbl[i].av, tbl[i].bv, tbl[i].yv, 0);
      check($sformatf("tbl%0d_sample_cnt", i), 64'(sample_cnt), 64'(tbl[i].e_samp));
      check($sformatf("tbl%0d_err_cnt", i), 64'(err_cnt), 64'(tbl[i].e_err));
      check($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].e_busy));
      check($sformatf("tbl%0d_done", i), 64'(done), 64'(tbl[i].e_done));
      check($sformatf("tbl%0d_pass", i), 64'(pass), 64'(tbl[i].e_pass));
      check($sformatf("tbl%0d_log_empty", i), 64'(log_empty), 64'(tbl[i].e_empty));
    end
    check("mismatch_log_data", 64'(log_rd_data), 64'(3'b101));
    cyc(0, 0, 0, 0, 0, 0, 1);
    check("mismatch_log_empty_after_pop", 64'(log_empty), 64'd1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    check("pop_when_empty", 64'(log_empty), 64'd1);

`ifndef AND_MON_STOP_ON_ERR_EN
    // Six mismatches into a four-deep log with no reads
    ov_list[0] = 3'b001; ov_list[1] = 3'b011; ov_list[2] = 3'b101;
    ov_list[3] = 3'b110; ov_list[4] = 3'b001; ov_list[5] = 3'b110;
    cyc(1, 10, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, ov_list[i][2], ov_list[i][1], ov_list[i][0], 0);
    check("ovf_err_cnt", 64'(err_cnt), 64'd6);
    check("ovf_flag", 64'(log_overflow), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf_read%0d", i), 64'(log_rd_data), 64'(ov_list[i]));
      cyc(0, 0, 0, 0, 0, 0, 1);
    end
    check("ovf_log_empty", 64'(log_empty), 64'd1);
    check("ovf_sticky", 64'(log_overflow), 64'd1);

    // Full log with simultaneous push and pop: both succeed, no overflow
    cyc(1, 10, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 1, 0, 0);
    cyc(0, 0, 1, 0, 0, 1, 1);
    check("full_pushpop_no_ovf", 64'(log_overflow), 64'd0);
    check("full_pushpop_head", 64'(log_rd_data), 64'(3'b110));
`else
    // Stop on first error: mismatch on sample 3 of 8
    cyc(1, 8, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 1, 1, 0);
    cyc(0, 0, 1, 0, 1, 0, 0);
    cyc(0, 0, 1, 1, 0, 1, 0);
    check("stop_done", 64'(done), 64'd1);
    check("stop_pass", 64'(pass), 64'd0);
    check("stop_sample_cnt", 64'(sample_cnt), 64'd3);
    check("stop_err_cnt", 64'(err_cnt), 64'd1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1, 1, 0, 0);
    check("stop_ignored_samples", 64'(sample_cnt), 64'd3);
    check("stop_ignored_errs", 64'(err_cnt), 64'd1);
`endif

    // Restart mid-run with a zero-length target
    cyc(1, 5, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 1, 1, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    check("zero_run_sample_cnt", 64'(sample_cnt), 64'd0);
    check("zero_run_done", 64'(done), 64'd1);
    check("zero_run_pass", 64'(pass), 64'd1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 0, 1, 0);
    check("done_ignores_valid", 64'(sample_cnt), 64'd0);

    // Asynchronous reset in the middle of a run with errors logged
    cyc(1, 10, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 1, 0, 0);
    cyc(0, 0, 1, 0, 0, 1, 0);
    start = 0; in_valid = 0; log_rd_en = 0;
    #4;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_err_cnt", 64'(err_cnt), 64'd0);
    check("arst_sample_cnt", 64'(sample_cnt), 64'd0);
    check("arst_log_empty", 64'(log_empty), 64'd1);
    check("arst_log_rd_data", 64'(log_rd_data), 64'd0);
    #2;
    rst_n = 1'b1;
    cyc(0, 0, 1, 1, 1, 0, 0);
    check("arst_idle_ignores_valid", 64'(sample_cnt), 64'd0);

    // Randomized traffic checked against the reference model
    cyc(1, 6, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      ra = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      cyc(($urandom_range(0, 19) == 0), int'($urandom_range(0, 12)),
          ($urandom_range(0, 3) != 0), ra, rb,
          (ra & rb) ^ ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 2) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
